// File: rtl/bin_to_bcd_serial_pkg.sv
// Shared definitions for the serial binary-to-BCD converter.
//   state_e       : FSM encoding (IDLE -> SHIFT -> FINISH)
//   BCD_MAX_DIGIT : largest legal decimal digit, used to build the saturated result
//   ADJ_THRESH    : a digit at or above this value gets corrected before a shift
//   ADJ_ADD       : the double-dabble correction amount
//   pow10_m1()    : 10^digits - 1, the largest value representable in 'digits' BCD digits
package bin_to_bcd_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] ADJ_THRESH    = 4'd5;
  localparam logic [3:0] ADJ_ADD       = 4'd3;

  function automatic logic [63:0] pow10_m1(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_serial_adjust.sv
// bcd_digit_adjust: combinational double-dabble correction for one BCD digit.
//   digit_i : 4-bit digit before the shift
//   digit_o : digit_i + 3 when digit_i >= 5, else digit_i unchanged
module bcd_digit_adjust
  import bin_to_bcd_serial_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // A digit >= 5 would become >= 10 after doubling; +3 makes the carry land
  // in the next digit instead.
  assign digit_o = (digit_i >= ADJ_THRESH) ? digit_i + ADJ_ADD : digit_i;

endmodule

// File: rtl/bin_to_bcd_serial.sv
// bin_to_bcd_serial: iterative double-dabble converter, one adjust+shift per clock.
//   clk       : system clock, rising edge
//   reset     : asynchronous active-low reset
//   start     : request conversion of bin_in (only honoured in IDLE)
//   bin_in    : unsigned binary value
//   busy      : high from the capture edge until the result is written
//   done      : one-cycle pulse after bcd_value/overflow are updated
//   overflow  : captured value exceeded 10^DIGITS-1 (result saturated to all 9s)
//   bcd_value : packed BCD result, digit 0 in [3:0]; holds until next completion
module bin_to_bcd_serial
  import bin_to_bcd_serial_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd_value
);

  localparam int          BCD_W   = 4 * DIGITS;
  localparam int          CNT_W   = $clog2(BIN_W + 1);
  localparam logic [63:0] SAT_LIM = pow10_m1(DIGITS);

  // The input must be wide enough to need the top digit, and must fit the
  // 64-bit arithmetic used for the saturation compare.
  if (BIN_W < 4 || BIN_W > 63 || DIGITS < 1 || DIGITS > 18 ||
      (((64'd1 << BIN_W) - 64'd1) < pow10_m1(DIGITS - 1) + 64'd1)) begin : g_param_check
    $error("bin_to_bcd_serial: unsupported BIN_W/DIGITS combination");
  end

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   bin_q,   bin_d;
  logic [BCD_W-1:0]   scr_q,   scr_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               sat_q,   sat_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic               ovf_q,   ovf_d;
  logic [BCD_W-1:0]   bcd_q,   bcd_d;
  logic [BCD_W-1:0]   scr_adj;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (scr_q[4*g +: 4]),
      .digit_o (scr_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    bcd_d   = bcd_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bin_d   = bin_in;
          scr_d   = '0;
          cnt_d   = CNT_W'(BIN_W);
          sat_d   = (64'(bin_in) > SAT_LIM);
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Adjust first, then shift the next binary MSB into digit 0.
        {scr_d, bin_d} = {scr_adj, bin_q} << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        // Scratch is meaningless when saturated (top digits were lost), so
        // substitute the largest representable value.
        bcd_d   = sat_q ? {DIGITS{BCD_MAX_DIGIT}} : scr_q;
        ovf_d   = sat_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign bcd_value = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Directed bench for bin_to_bcd_serial (BIN_W=14, DIGITS=4).
module tb_bin_to_bcd_serial;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] bin_in;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] bcd_value;

  int vectors     = 0;
  int miscompares = 0;
  int starts      = 0;
  int dones       = 0;

  bin_to_bcd_serial #(.BIN_W(14), .DIGITS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bin_in    (bin_in),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .bcd_value (bcd_value)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) dones++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    int t;
    t = (v > 9999) ? 9999 : v;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Called at a negedge; returns at the negedge where done is seen, so the
  // next call lands on the first accepting edge (back-to-back).
  task automatic convert(input logic [13:0] v, input logic [15:0] exp_bcd,
                         input logic exp_ovf, input string tag);
    int n;
    bit busy_ok;
    logic [15:0] b;
    bin_in = v;
    start  = 1'b1;
    starts++;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    busy_ok = 1'b1;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) break;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    // 16th negedge after capture = cycle following the 15th edge
    check({tag, " done_cycle"}, n, 16);
    check({tag, " busy_during"}, 32'(busy_ok), 1);
    check({tag, " busy_at_done"}, 32'(busy), 0);
    check({tag, " bcd"}, 32'(bcd_value), 32'(exp_bcd));
    check({tag, " ovf"}, 32'(overflow), 32'(exp_ovf));
    b = bcd_value;
    for (int d = 0; d < 4; d++)
      check({tag, " digit_le9"}, 32'(b[4*d +: 4] <= 4'd9), 1);
  endtask

  initial begin
    int n;
    int seen;
    reset  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    #12;
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst ovf",  32'(overflow), 0);
    check("rst bcd",  32'(bcd_value), 0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);

    convert(14'd1234, 16'h1234, 1'b0, "c1234");

    // back-to-back, each issued on the first accepting edge
    convert(14'd0,    16'h0000, 1'b0, "c0");
    convert(14'd9999, 16'h9999, 1'b0, "c9999");
    convert(14'd10,   16'h0010, 1'b0, "c10");

    convert(14'd12000, 16'h9999, 1'b1, "c12000");
    convert(14'd5,     16'h0005, 1'b0, "c5");
    convert(14'd10000, 16'h9999, 1'b1, "c10000");
    convert(14'd16383, 16'h9999, 1'b1, "c16383");

    // start held high; bin_in changes mid-conversion
    bin_in = 14'd777;
    start  = 1'b1;
    starts += 2;
    @(posedge clk);
    n = 0;
    repeat (5) begin @(negedge clk); n++; end
    bin_in = 14'd4321;
    while (n < 25) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) break;
    end
    check("hold first done_cycle", n, 16);
    check("hold first bcd", 32'(bcd_value), 32'h0777);
    check("hold first ovf", 32'(overflow), 0);
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (n < 25) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) break;
    end
    check("hold second done_cycle", n, 16);
    check("hold second bcd", 32'(bcd_value), 32'h4321);

    // make outputs nonzero so the reset clear is visible
    @(negedge clk);
    convert(14'd12000, 16'h9999, 1'b1, "pre_rst");

    // abort 8888 six cycles in; aborted conversion produces no done
    bin_in = 14'd8888;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort busy", 32'(busy), 0);
    check("abort done", 32'(done), 0);
    check("abort ovf",  32'(overflow), 0);
    check("abort bcd",  32'(bcd_value), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done !== 1'b0) seen++;
    end
    check("abort no_done", seen, 0);
    check("abort bcd_hold", 32'(bcd_value), 0);
    convert(14'd42, 16'h0042, 1'b0, "c42");

    // strided sweep against the decimal model
    for (int v = 0; v <= 9999; v += 7)
      convert(14'(v), ref_bcd(v), 1'b0, "sweep");

    @(negedge clk);
    check("done_count", dones, starts);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
